// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// held output byte with valid/frame-error strobes and a wrapping good-byte count.
module uart_rx_byte #(
   parameter int CLKS_PER_BIT = 868,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   output logic [7:0]       rx_data,
   output logic             rx_valid,
   output logic             frame_err,
   output logic             busy,
   output logic [CNT_W-1:0] rx_count
);

   localparam int          HALF        = CLKS_PER_BIT / 2;
   localparam logic [15:0] BT_HALF_END = 16'(HALF - 1);
   localparam logic [15:0] BT_BIT_END  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   state_t           state, state_n;
   logic             rx_meta, rxs;
   logic [15:0]      bt, bt_n;
   logic [2:0]       bit_idx, bit_idx_n;
   logic [7:0]       shift, shift_n;
   logic [7:0]       data_n;
   logic             valid_n, ferr_n;
   logic [CNT_W-1:0] count_n;

   // The synchroniser resets to idle-high so a quiet line is not mistaken for a start bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rxs     <= 1'b1;
      end else begin
         rx_meta <= rx;
         rxs     <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bt        <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         rx_count  <= '0;
      end else begin
         state     <= state_n;
         bt        <= bt_n;
         bit_idx   <= bit_idx_n;
         shift     <= shift_n;
         rx_data   <= data_n;
         rx_valid  <= valid_n;
         frame_err <= ferr_n;
         rx_count  <= count_n;
      end
   end

   // START waits half a bit, so every later sample falls one full bit later at a bit centre.
   always_comb begin
      state_n   = state;
      bt_n      = bt + 16'd1;
      bit_idx_n = bit_idx;
      shift_n   = shift;
      data_n    = rx_data;
      valid_n   = 1'b0;
      ferr_n    = 1'b0;
      count_n   = rx_count;
      case (state)
         IDLE: begin
            bt_n = '0;
            if (!rxs) begin
               state_n = START;
            end
         end
         START: begin
            if (bt == BT_HALF_END) begin
               bt_n = '0;
               if (rxs) begin
                  state_n = IDLE;
               end else begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end
            end
         end
         DATA: begin
            if (bt == BT_BIT_END) begin
               bt_n      = '0;
               shift_n   = {rxs, shift[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_n = STOP;
               end
            end
         end
         STOP: begin
            if (bt == BT_BIT_END) begin
               bt_n = '0;
               if (rxs) begin
                  data_n  = shift;
                  valid_n = 1'b1;
                  count_n = rx_count + CNT_W'(1);
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = BREAK;
               end
            end
         end
         BREAK: begin
            bt_n = '0;
            if (rxs) begin
               state_n = IDLE;
            end
         end
         default: begin
            bt_n    = '0;
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Scoreboard bench for uart_rx_byte: frames are serialised at 16 clk/bit, expected
// bytes are queued when a frame is sent and matched against captured rx_valid bytes.
`timescale 1ns/1ps
module tb_uart_rx_byte;

   localparam int CPB   = 16;
   localparam int HALF  = CPB / 2;
   localparam int CNT_W = 4;

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             rx    = 1'b1;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic             frame_err;
   logic             busy;
   logic [CNT_W-1:0] rx_count;

   uart_rx_byte #(.CLKS_PER_BIT(CPB), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .reset(rst_n),
      .rx(rx),
      .rx_data(rx_data),
      .rx_valid(rx_valid),
      .frame_err(frame_err),
      .busy(busy),
      .rx_count(rx_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int valid_cnt = 0;
   int ferr_cnt  = 0;
   int both_cnt  = 0;

   logic [7:0]       exp_q[$];
   logic [7:0]       got_q[$];
   int               got_cyc_q[$];
   logic [7:0]       exp_data  = 8'h00;
   logic [CNT_W-1:0] exp_count = '0;

   always @(posedge clk) cyc <= cyc + 1;

   // Capture every strobe on the falling edge, away from the sampling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (rx_valid) begin
            got_q.push_back(rx_data);
            got_cyc_q.push_back(cyc);
            valid_cnt++;
         end
         if (frame_err) ferr_cnt++;
         if (rx_valid && frame_err) both_cnt++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Caller must be at posedge+1; leaves rx at the stop-bit value.
   task automatic send_frame(input logic [7:0] b, input logic stop_v, output int start_cyc);
      start_cyc = cyc;
      if (stop_v) exp_q.push_back(b);
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         tick(CPB);
      end
      rx = stop_v;
      tick(CPB);
   endtask

   task automatic wait_for_output();
      for (int k = 0; k < 40 && got_q.size() < exp_q.size(); k++) tick(1);
   endtask

   task automatic test_reset();
      logic busy_seen;
      busy_seen = 1'b0;
      rst_n = 1'b0;
      for (int i = 0; i < 24; i++) begin
         rx = 1'($urandom_range(0, 1));
         tick(1);
         if (busy || rx_valid || frame_err) busy_seen = 1'b1;
      end
      n_checks++;
      if (busy_seen !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL reset_quiet: outputs active during reset %b, expected 0", busy_seen);
      end
      n_checks++;
      if (rx_data !== 8'h00) begin
         n_fail++;
         $display("[TB] FAIL reset_data: got %h expected 00", rx_data);
      end
      n_checks++;
      if (rx_count !== '0) begin
         n_fail++;
         $display("[TB] FAIL reset_count: got %0d expected 0", rx_count);
      end
      rx = 1'b1;
      rst_n = 1'b1;
      tick(6);
      n_checks++;
      if (busy !== 1'b0 || valid_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL reset_release_idle: busy %b valid_cnt %0d expected 0 0", busy, valid_cnt);
      end
   endtask

   task automatic test_single();
      int sc, v0, lat;
      logic [7:0] e, g;
      v0 = valid_cnt;
      send_frame(8'hA5, 1'b1, sc);
      exp_data  = 8'hA5;
      exp_count = exp_count + 1'b1;
      wait_for_output();
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL single_timeout: got no byte, expected A5");
      end else begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         lat = got_cyc_q.pop_front() - sc;
         if (g !== e) begin
            n_fail++;
            $display("[TB] FAIL single_byte: got %h expected %h", g, e);
         end
         n_checks++;
         if (lat < 9 * CPB + HALF + 2 || lat > 9 * CPB + HALF + 4) begin
            n_fail++;
            $display("[TB] FAIL single_latency: got %0d clk expected %0d +-1", lat, 9 * CPB + HALF + 3);
         end
      end
      n_checks++;
      if (valid_cnt - v0 != 1) begin
         n_fail++;
         $display("[TB] FAIL single_pulses: got %0d expected 1", valid_cnt - v0);
      end
      n_checks++;
      if (rx_data !== exp_data || rx_count !== exp_count) begin
         n_fail++;
         $display("[TB] FAIL single_hold: data %h count %0d expected %h %0d", rx_data, rx_count, exp_data, exp_count);
      end
   endtask

   task automatic test_back_to_back();
      int sc, v0, f0;
      logic [7:0] e, g;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h3C, 1'b1, sc);
      send_frame(8'hFF, 1'b1, sc);
      exp_data  = 8'hFF;
      exp_count = exp_count + 2'd2;
      wait_for_output();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_timeout: byte %0d missing", i);
         end else begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            void'(got_cyc_q.pop_front());
            if (g !== e) begin
               n_fail++;
               $display("[TB] FAIL b2b_byte%0d: got %h expected %h", i, g, e);
            end
         end
      end
      n_checks++;
      if (valid_cnt - v0 != 2 || ferr_cnt != f0) begin
         n_fail++;
         $display("[TB] FAIL b2b_pulses: valid %0d ferr %0d expected 2 0", valid_cnt - v0, ferr_cnt - f0);
      end
      n_checks++;
      if (rx_data !== exp_data || rx_count !== exp_count) begin
         n_fail++;
         $display("[TB] FAIL b2b_hold: data %h count %0d expected %h %0d", rx_data, rx_count, exp_data, exp_count);
      end
   endtask

   task automatic test_glitch();
      int v0, busy_cycles;
      v0 = valid_cnt;
      busy_cycles = 0;
      rx = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick(1);
         if (busy) busy_cycles++;
      end
      rx = 1'b1;
      for (int i = 0; i < 3 * CPB; i++) begin
         tick(1);
         if (busy) busy_cycles++;
      end
      n_checks++;
      if (busy_cycles > HALF + 1 || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL glitch_busy: busy %0d cycles (now %b) expected <= %0d and 0", busy_cycles, busy, HALF + 1);
      end
      n_checks++;
      if (valid_cnt != v0 || rx_count !== exp_count || ferr_cnt != 0) begin
         n_fail++;
         $display("[TB] FAIL glitch_quiet: pulses %0d count %0d ferr %0d expected 0 %0d 0", valid_cnt - v0, rx_count, ferr_cnt, exp_count);
      end
   endtask

   task automatic test_frame_err();
      int sc, v0, f0, k;
      v0 = valid_cnt;
      f0 = ferr_cnt;
      send_frame(8'h12, 1'b0, sc);
      tick(3 * CPB);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("[TB] FAIL ferr_break_busy: got %b expected 1", busy);
      end
      rx = 1'b1;
      for (k = 0; k < 10 && busy; k++) tick(1);
      n_checks++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL ferr_release: busy %b expected 0", busy);
      end
      n_checks++;
      if (ferr_cnt - f0 != 1 || valid_cnt != v0) begin
         n_fail++;
         $display("[TB] FAIL ferr_pulses: ferr %0d valid %0d expected 1 0", ferr_cnt - f0, valid_cnt - v0);
      end
      n_checks++;
      if (rx_data !== exp_data || rx_count !== exp_count) begin
         n_fail++;
         $display("[TB] FAIL ferr_hold: data %h count %0d expected %h %0d", rx_data, rx_count, exp_data, exp_count);
      end
      tick(CPB);
   endtask

   task automatic test_reset_mid_frame();
      int sc, v0;
      logic [7:0] e, g;
      logic [7:0] part;
      part = 8'h55;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = part[i];
         tick(CPB);
      end
      rx = 1'b0;
      rst_n = 1'b0;
      tick(3);
      exp_data  = 8'h00;
      exp_count = '0;
      n_checks++;
      if (rx_data !== exp_data || rx_count !== exp_count || busy !== 1'b0) begin
         n_fail++;
         $display("[TB] FAIL midreset_clear: data %h count %0d busy %b expected 00 0 0", rx_data, rx_count, busy);
      end
      v0 = valid_cnt;
      rst_n = 1'b1;
      send_frame(8'h5A, 1'b1, sc);
      exp_data  = 8'h5A;
      exp_count = exp_count + 1'b1;
      wait_for_output();
      n_checks++;
      if (got_q.size() == 0) begin
         n_fail++;
         $display("[TB] FAIL midreset_timeout: no byte after low-line release, expected 5A");
      end else begin
         e = exp_q.pop_front();
         g = got_q.pop_front();
         void'(got_cyc_q.pop_front());
         if (g !== e) begin
            n_fail++;
            $display("[TB] FAIL midreset_byte: got %h expected %h", g, e);
         end
      end
      n_checks++;
      if (valid_cnt - v0 != 1 || rx_count !== exp_count) begin
         n_fail++;
         $display("[TB] FAIL midreset_count: pulses %0d count %0d expected 1 %0d", valid_cnt - v0, rx_count, exp_count);
      end
   endtask

   task automatic test_count_wrap();
      int sc, v0;
      logic [7:0] e, g;
      rst_n = 1'b0;
      rx = 1'b1;
      tick(2);
      rst_n = 1'b1;
      tick(3);
      exp_count = '0;
      exp_data  = 8'h00;
      for (int i = 0; i < 16; i++) begin
         send_frame(8'h00, 1'b1, sc);
         exp_count = exp_count + 1'b1;
         wait_for_output();
         n_checks++;
         if (got_q.size() == 0) begin
            n_fail++;
            $display("[TB] FAIL wrap_timeout: byte %0d missing", i);
         end else begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            void'(got_cyc_q.pop_front());
            if (g !== e || rx_count !== exp_count) begin
               n_fail++;
               $display("[TB] FAIL wrap_step%0d: byte %h count %0d expected %h %0d", i, g, rx_count, e, exp_count);
            end
         end
      end
      n_checks++;
      if (rx_count !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL wrap_zero: got %0d expected 0", rx_count);
      end
      v0 = valid_cnt;
      rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         rx = 1'b1;
         tick(CPB);
      end
      rst_n = 1'b0;
      tick(2);
      n_checks++;
      if (rx_data !== 8'h00 || valid_cnt != v0 || rx_count !== 4'd0) begin
         n_fail++;
         $display("[TB] FAIL wrap_midreset: data %h pulses %0d count %0d expected 00 0 0", rx_data, valid_cnt - v0, rx_count);
      end
      rx = 1'b1;
      rst_n = 1'b1;
      tick(4);
   endtask

   task automatic test_exclusive();
      n_checks++;
      if (both_cnt != 0 || exp_q.size() != 0 || got_q.size() != 0) begin
         n_fail++;
         $display("[TB] FAIL exclusive_leftover: both %0d exp %0d got %0d expected 0 0 0", both_cnt, exp_q.size(), got_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      tick(CPB);
      test_back_to_back();
      tick(CPB);
      test_glitch();
      test_frame_err();
      test_reset_mid_frame();
      tick(CPB);
      test_count_wrap();
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
